// File: rtl/nn_fixed_pkg.sv
// Shared Q4.4 fixed-point definitions for the neural-network datapath.
// Used by the MAC neuron, the activation function and the interpolator.
package nn_fixed_pkg;

   localparam int DATA_W = 8;
   localparam int FRAC_W = 4;
   localparam int SAT_W  = 32;

   typedef logic signed [DATA_W-1:0] q4_4_t;

   localparam q4_4_t Q_MAX = 8'sh7F;
   localparam q4_4_t Q_MIN = 8'sh80;

   localparam logic signed [SAT_W-1:0] SAT_HI = 32'sd127;
   localparam logic signed [SAT_W-1:0] SAT_LO = -32'sd128;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } mac_state_t;

   // Accumulator is Q.(2*FRAC_W); drop FRAC_W bits by floor, then clip to Q4.4.
   function automatic q4_4_t sat_q44(input logic signed [SAT_W-1:0] acc);
      logic signed [SAT_W-1:0] t;
      t = acc >>> FRAC_W;
      if (t > SAT_HI) begin
         return Q_MAX;
      end else if (t < SAT_LO) begin
         return Q_MIN;
      end
      return t[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/nn_sat_rescale.sv
// Combinational rescale of a wide Q.8 accumulator down to a saturated Q4.4 value.
module nn_sat_rescale
   import nn_fixed_pkg::*;
#(
   parameter int ACC_W = 20
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic        [DATA_W-1:0] z
);

   logic signed [SAT_W-1:0] acc_ext;

   assign acc_ext = SAT_W'(acc);
   assign z       = sat_q44(acc_ext);

endmodule

// File: rtl/neuron_mac_serial.sv
// Serial multiply-accumulate neuron: z = bias + sum(x[i]*w[i]), one pair per handshake,
// rescaled and saturated to Q4.4 for the downstream activation function.
module neuron_mac_serial #(
   parameter int N_INPUTS = 2,
   parameter int DATA_W   = 8,
   parameter int FRAC_W   = 4,
   parameter int ACC_W    = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] bias,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] w_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] z_value,
   output logic              z_valid,
   input  logic              z_ready,
   output logic              busy
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   nn_fixed_pkg::mac_state_t state;
   nn_fixed_pkg::mac_state_t state_next;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_aligned;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_sum;
   logic        [CNT_W-1:0]    cnt;
   logic        [DATA_W-1:0]   z_sat;
   logic                       take;
   logic                       last;

   assign prod         = $signed(x_in) * $signed(w_in);
   assign prod_ext     = ACC_W'(prod);
   assign bias_aligned = ACC_W'($signed(bias)) <<< FRAC_W;
   assign acc_sum      = acc + prod_ext;

   // The handshake is qualified by state directly so in_ready stays a pure FSM output.
   assign take = in_valid && (state == nn_fixed_pkg::ACCUM);
   assign last = take && (cnt == CNT_W'(N_INPUTS - 1));

   // Saturation sees the sum including the final product, so z_value is ready on that edge.
   nn_sat_rescale #(
      .ACC_W (ACC_W)
   ) u_sat (
      .acc (acc_sum),
      .z   (z_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= nn_fixed_pkg::IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      z_valid    = 1'b0;
      busy       = 1'b1;
      case (state)
         nn_fixed_pkg::IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = nn_fixed_pkg::ACCUM;
            end
         end
         nn_fixed_pkg::ACCUM: begin
            in_ready = 1'b1;
            if (last) begin
               state_next = nn_fixed_pkg::DONE;
            end
         end
         nn_fixed_pkg::DONE: begin
            z_valid = 1'b1;
            if (z_ready) begin
               state_next = nn_fixed_pkg::IDLE;
            end
         end
         default: begin
            state_next = nn_fixed_pkg::IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         z_value <= '0;
      end else begin
         if ((state == nn_fixed_pkg::IDLE) && start) begin
            acc <= bias_aligned;
            cnt <= '0;
         end
         if (take) begin
            acc <= acc_sum;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
               z_value <= z_sat;
            end
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac_serial.sv
// Randomized self-checking bench for neuron_mac_serial against an integer reference model.
module tb_neuron_mac_serial;

   localparam int N = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] bias;
   logic [7:0] x_in;
   logic [7:0] w_in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] z_value;
   logic       z_valid;
   logic       z_ready;
   logic       busy;

   int total_checks = 0;
   int bad_checks   = 0;
   int cyc          = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   neuron_mac_serial #(
      .N_INPUTS (N),
      .DATA_W   (8),
      .FRAC_W   (4),
      .ACC_W    (20)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bias     (bias),
      .x_in     (x_in),
      .w_in     (w_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .z_value  (z_value),
      .z_valid  (z_valid),
      .z_ready  (z_ready),
      .busy     (busy)
   );

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Real-valued view: z = floor((bias*16 + sum x*w) / 16), clipped to [-128,127].
   function automatic logic [7:0] model_z(input int b, input int xs[N], input int ws[N]);
      int acc;
      int t;
      acc = b * 16;
      for (int i = 0; i < N; i++) acc += xs[i] * ws[i];
      if (acc >= 0) t = acc / 16;
      else          t = -((-acc + 15) / 16);
      if (t > 127)       t = 127;
      else if (t < -128) t = -128;
      return 8'(t);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic [7:0] xa[N],
                                input logic [7:0] wa[N], input int gaps[N], input int hold,
                                input bit start_at_release, output logic [7:0] z_got);
      int xi[N];
      int wi[N];
      logic [7:0] exp_z;
      for (int i = 0; i < N; i++) begin
         xi[i] = int'($signed(xa[i]));
         wi[i] = int'($signed(wa[i]));
      end
      exp_z = model_z(int'($signed(b)), xi, wi);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      bias  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      bias  = 8'($urandom);
      checkOutput("accum_busy", 32'(busy), 32'd1);
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b0;
         repeat (gaps[i]) begin
            x_in = 8'($urandom);
            w_in = 8'($urandom);
            tick();
         end
         checkOutput("in_ready", 32'(in_ready), 32'd1);
         checkOutput("z_valid_early", 32'(z_valid), 32'd0);
         x_in     = xa[i];
         w_in     = wa[i];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      x_in     = 8'($urandom);
      checkOutput("z_valid_rise", 32'(z_valid), 32'd1);
      checkOutput("z_value", 32'(z_value), 32'(exp_z));
      z_got = z_value;
      for (int h = 0; h < hold; h++) begin
         start = 1'b1;
         tick();
         checkOutput("hold_valid", 32'(z_valid), 32'd1);
         checkOutput("hold_value", 32'(z_value), 32'(exp_z));
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      start   = start_at_release;
      z_ready = 1'b1;
      tick();
      z_ready = 1'b0;
      start   = 1'b0;
      checkOutput("release_valid", 32'(z_valid), 32'd0);
      checkOutput("release_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] xa[N];
      logic [7:0] wa[N];
      int         gaps[N];
      int         xi[N];
      int         wi[N];
      logic [7:0] z_got;
      logic [7:0] exp_z;
      logic [7:0] b;
      int         prev_cyc;

      rst      = 1'b1;
      start    = 1'b0;
      bias     = 8'h00;
      x_in     = 8'h00;
      w_in     = 8'h00;
      in_valid = 1'b0;
      z_ready  = 1'b0;
      #12;
      checkOutput("rst_z_value", 32'(z_value), 32'd0);
      checkOutput("rst_z_valid", 32'(z_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] known-answer vectors");
      xa = '{8'h10, 8'h10}; wa = '{8'h20, 8'h20}; gaps = '{0, 0};
      applyStimulus(8'hF0, xa, wa, gaps, 0, 1'b0, z_got);
      checkOutput("xor_node", 32'(z_got), 32'h30);

      xa = '{8'h7F, 8'h7F}; wa = '{8'h7F, 8'h7F};
      applyStimulus(8'h00, xa, wa, gaps, 0, 1'b0, z_got);
      checkOutput("pos_sat", 32'(z_got), 32'h7F);

      xa = '{8'h80, 8'h80}; wa = '{8'h7F, 8'h7F};
      applyStimulus(8'h00, xa, wa, gaps, 0, 1'b0, z_got);
      checkOutput("neg_sat", 32'(z_got), 32'h80);

      xa = '{8'hFF, 8'h00}; wa = '{8'h01, 8'h00};
      applyStimulus(8'h00, xa, wa, gaps, 0, 1'b0, z_got);
      checkOutput("floor_neg", 32'(z_got), 32'hFF);

      $display("[TB] stalls and backpressure");
      xa = '{8'h10, 8'h10}; wa = '{8'h20, 8'h20}; gaps = '{3, 1};
      applyStimulus(8'hF0, xa, wa, gaps, 4, 1'b1, z_got);
      checkOutput("stall_xor", 32'(z_got), 32'h30);

      $display("[TB] reset mid-accumulation");
      bias  = 8'hF0;
      start = 1'b1;
      tick();
      start    = 1'b0;
      x_in     = 8'h10;
      w_in     = 8'h20;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_z_value", 32'(z_value), 32'd0);
      checkOutput("mid_rst_z_valid", 32'(z_valid), 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      gaps = '{0, 0};
      applyStimulus(8'hF0, xa, wa, gaps, 0, 1'b0, z_got);
      checkOutput("post_rst_xor", 32'(z_got), 32'h30);

      $display("[TB] back-to-back evaluations");
      z_ready  = 1'b1;
      prev_cyc = 0;
      for (int k = 0; k < 5; k++) begin
         b = 8'($urandom);
         for (int i = 0; i < N; i++) begin
            xa[i] = 8'($urandom);
            wa[i] = 8'($urandom);
            xi[i] = int'($signed(xa[i]));
            wi[i] = int'($signed(wa[i]));
         end
         exp_z = model_z(int'($signed(b)), xi, wi);
         bias  = b;
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int i = 0; i < N; i++) begin
            x_in     = xa[i];
            w_in     = wa[i];
            in_valid = 1'b1;
            tick();
         end
         in_valid = 1'b0;
         checkOutput("b2b_valid", 32'(z_valid), 32'd1);
         checkOutput("b2b_value", 32'(z_value), 32'(exp_z));
         if (k > 0) checkOutput("b2b_period", 32'(cyc - prev_cyc), 32'(N + 2));
         prev_cyc = cyc;
         tick();
      end
      z_ready = 1'b0;
      checkOutput("b2b_idle", 32'(busy), 32'd0);

      $display("[TB] randomized evaluations");
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < N; i++) begin
            xa[i]   = 8'($urandom);
            wa[i]   = 8'($urandom);
            gaps[i] = int'($urandom_range(0, 3));
         end
         applyStimulus(8'($urandom), xa, wa, gaps, int'($urandom_range(0, 3)),
                       1'($urandom), z_got);
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
